hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller on the far side of the ID/EX register.
- Consumes ID/EX outputs (MemRead, rd) plus IF/ID source registers and the EX/MEM branch-taken decision.
- Drives the Flush input of ID_EX and the write/flush enables of PC and IF/ID.
- Sequences load-use stalls and branch flushes with a small FSM and a cycle counter.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal range 1..15)
FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed after a taken branch (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
ifid_rs1  input  5  rs1 of instruction in ID
ifid_rs2  input  5  rs2 of instruction in ID
ifid_uses_rs2  input  1  instruction in ID reads rs2 (R-type, store, branch)
idex_MemRead  input  1  MemRead_out of ID/EX
idex_rd  input  5  rd_out of ID/EX
exmem_branch_taken  input  1  Branch & Zero from EX/MEM
PCWrite  output  1  PC update enable
IFID_Write  output  1  IF/ID load enable
IFID_Flush  output  1  clear IF/ID
IDEX_Flush  output  1  drives ID_EX Flush (bubble)
haz_state  output  2  current FSM state (debug)
stall_count  output  32  load-use stall cycles (HAZARD_STATS_EN only)
flush_count  output  32  flush cycles (HAZARD_STATS_EN only)

Behaviour:
- State register and 4-bit counter `cnt` are asynchronously cleared when reset=0: state=RUN, cnt=0.
- Outputs are Mealy (combinational from state and inputs); action takes effect at the next rising clk.
- While reset=0, outputs are forced: PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, haz_state=RUN.
- load_use = idex_MemRead && idex_rd!=0 && (idex_rd==ifid_rs1 || (ifid_uses_rs2 && idex_rd==ifid_rs2)).
- Priority in every state: exmem_branch_taken > remaining state action > load_use.
- RUN, default outputs: PCWrite=1, IFID_Write=1, both flushes 0.
- RUN, branch_taken: IFID_Flush=1, IDEX_Flush=1, PCWrite=1.
  - If FLUSH_CYCLES>1, go FLUSH with cnt=FLUSH_CYCLES-1; else stay RUN.
- RUN, load_use (no branch): PCWrite=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0.
  - If LOAD_STALL_CYCLES>1, go STALL with cnt=LOAD_STALL_CYCLES-1; else stay RUN.
- STALL, no branch: same outputs as the RUN load_use case.
  - cnt decrements each cycle; when cnt==1 on entry to the cycle, next state is RUN.
  - load_use is not re-evaluated inside STALL.
- STALL, branch_taken: stall is abandoned; outputs and transition are identical to RUN+branch_taken.
- FLUSH: IFID_Flush=1, IDEX_Flush=1, PCWrite=1, IFID_Write=1.
  - cnt decrements; return to RUN after cnt reaches 0.
  - A new branch_taken reloads cnt=FLUSH_CYCLES-1.
- haz_state encoding: RUN=0, STALL=1, FLUSH=2; 3 is unreachable and recovers to RUN on the next clk.
- rd==x0 never stalls. Simultaneous branch and load_use in one cycle: flush only.
- Reset mid-STALL/FLUSH aborts immediately; no residual bubbles after release.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_count increments on each clk where IDEX_Flush=1 && PCWrite=0.
  - flush_count increments on each clk where IFID_Flush=1 && reset=1.
  - Both counters saturate at 32'hFFFFFFFF and clear asynchronously on reset=0.
- Undefined: no counter flops; both ports present and tied to 0.

Decomposition:
- Shared package hazard_pkg holds:
  - state encodings HAZ_RUN=2'd0, HAZ_STALL=2'd1, HAZ_FLUSH=2'd2
  - constant REG_X0=5'd0
  - counter width CNT_W=4
- Sub-module hazard_cmp: purely combinational load_use detector (rs1/rs2/rd/MemRead/uses_rs2 in, load_use out); reused by a future forwarding unit.

Test Plan:
- Reset released with all inputs 0 -> first cycle PCWrite=1, IFID_Write=1, both flushes 0, haz_state=0.
- idex_MemRead=1, idex_rd=5, ifid_rs1=5, defaults -> one cycle PCWrite=0, IFID_Write=0, IDEX_Flush=1, then back to normal; with LOAD_STALL_CYCLES=3 exactly 3 such cycles, haz_state=1 for cycles 2-3.
- idex_MemRead=1, idex_rd=0, ifid_rs1=0 -> no stall; idex_rd=7, ifid_rs2=7, ifid_uses_rs2=0 -> no stall.
- exmem_branch_taken=1 together with a load_use condition -> IFID_Flush=1, IDEX_Flush=1, PCWrite=1; no stall cycle follows; FLUSH_CYCLES=2 gives 2 flush cycles.
- LOAD_STALL_CYCLES=4, branch_taken pulsed in stall cycle 2 -> stall aborted, flush asserted that cycle, RUN next cycle.
- reset=0 asserted mid-FLUSH (FLUSH_CYCLES=5) -> haz_state=0 immediately; after release normal outputs, no leftover flush; with HAZARD_STATS_EN both counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - haz_state_e : FSM state encodings (RUN=0, STALL=1, FLUSH=2; 3 unused)
//   - REG_X0      : architectural zero register index
//   - CNT_W       : width of the stall/flush cycle counter
package hazard_pkg;

    localparam int CNT_W = 4;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        HAZ_RUN   = 2'd0,
        HAZ_STALL = 2'd1,
        HAZ_FLUSH = 2'd2
    } haz_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational load-use hazard detector.
// Flags when the load in ID/EX writes a register that the instruction in ID
// reads. Writes to x0 are never a hazard.
// Ports:
//   rs1_i, rs2_i  : source registers of the instruction in ID
//   uses_rs2_i    : instruction in ID actually reads rs2
//   mem_read_i    : instruction in ID/EX is a load
//   rd_i          : destination register of the instruction in ID/EX
//   load_use_o    : hazard detected
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       uses_rs2_i,
    input  logic       mem_read_i,
    input  logic [4:0] rd_i,
    output logic       load_use_o
);

    assign load_use_o = mem_read_i && (rd_i != REG_X0) &&
                        ((rd_i == rs1_i) || (uses_rs2_i && (rd_i == rs2_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller sitting after the ID/EX register.
// Inserts load-use bubbles and flushes IF/ID + ID/EX after a taken branch.
// Outputs are Mealy (state + current inputs) and act at the next rising clk.
// Optional build macro: HAZARD_STATS_EN enables saturating stall/flush
// cycle counters; without it stall_count/flush_count are tied to 0.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   ifid_rs1/rs2/uses_rs2     : source operands of the instruction in ID
//   idex_MemRead, idex_rd     : load flag and destination in ID/EX
//   exmem_branch_taken        : resolved taken branch from EX/MEM
//   PCWrite, IFID_Write       : PC / IF/ID load enables
//   IFID_Flush, IDEX_Flush    : pipeline register clears
//   haz_state                 : current FSM state (debug)
//   stall_count, flush_count  : statistics counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        ifid_uses_rs2,
    input  logic        idex_MemRead,
    input  logic [4:0]  idex_rd,
    input  logic        exmem_branch_taken,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic [1:0]  haz_state,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    // The cycle that detects the event is itself the first bubble/flush, so
    // the counter is loaded with the number of cycles still remaining.
    localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam bit               STALL_MULTI  = (LOAD_STALL_CYCLES > 1);
    localparam bit               FLUSH_MULTI  = (FLUSH_CYCLES > 1);

    haz_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    hazard_cmp u_cmp (
        .rs1_i      (ifid_rs1),
        .rs2_i      (ifid_rs2),
        .uses_rs2_i (ifid_uses_rs2),
        .mem_read_i (idex_MemRead),
        .rd_i       (idex_rd),
        .load_use_o (load_use)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HAZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        PCWrite    = 1'b1;
        IFID_Write = 1'b1;
        IFID_Flush = 1'b0;
        IDEX_Flush = 1'b0;

        // A taken branch wins in every state: flush, keep fetching the target,
        // and (re)start the flush window. Any pending stall is abandoned.
        if (exmem_branch_taken) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
            if (FLUSH_MULTI) begin
                state_d = HAZ_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = HAZ_RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                HAZ_RUN: begin
                    if (load_use) begin
                        PCWrite    = 1'b0;
                        IFID_Write = 1'b0;
                        IDEX_Flush = 1'b1;
                        if (STALL_MULTI) begin
                            state_d = HAZ_STALL;
                            cnt_d   = STALL_RELOAD;
                        end
                    end
                end
                HAZ_STALL: begin
                    // load_use is deliberately ignored here: the frozen ID
                    // instruction is already being waited for.
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_Flush = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = HAZ_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                HAZ_FLUSH: begin
                    IFID_Flush = 1'b1;
                    IDEX_Flush = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = HAZ_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = HAZ_RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        // Hold the pipeline frozen and cleared for as long as reset is low.
        if (!reset) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end
    end

    assign haz_state = state_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (IDEX_Flush && !PCWrite && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (IFID_Flush && reset && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances with different stall/flush lengths
// share one stimulus stream; a cycle-count reference model predicts outputs.
module tb_hazard_ctrl;

    localparam int N = 3;
    // Per-instance lengths, 4 bits each: inst0 L=3 F=2, inst1 L=4 F=5, inst2 L=1 F=1
    localparam bit [11:0] LSC_V = {4'd1, 4'd4, 4'd3};
    localparam bit [11:0] FLC_V = {4'd1, 4'd5, 4'd2};

    logic        clk;
    logic        reset;
    logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
    logic        ifid_uses_rs2, idex_MemRead, exmem_branch_taken;

    logic [N-1:0] pcw, ifw, iffl, idfl;
    logic [1:0]   hs [N];
    logic [31:0]  sc [N];
    logic [31:0]  fc [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        hazard_ctrl #(
            .LOAD_STALL_CYCLES (int'(LSC_V[g*4 +: 4])),
            .FLUSH_CYCLES      (int'(FLC_V[g*4 +: 4]))
        ) u_dut (
            .clk                (clk),
            .reset              (reset),
            .ifid_rs1           (ifid_rs1),
            .ifid_rs2           (ifid_rs2),
            .ifid_uses_rs2      (ifid_uses_rs2),
            .idex_MemRead       (idex_MemRead),
            .idex_rd            (idex_rd),
            .exmem_branch_taken (exmem_branch_taken),
            .PCWrite            (pcw[g]),
            .IFID_Write         (ifw[g]),
            .IFID_Flush         (iffl[g]),
            .IDEX_Flush         (idfl[g]),
            .haz_state          (hs[g]),
            .stall_count        (sc[g]),
            .flush_count        (fc[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: bubbles / flush cycles still owed after the current one.
    int          stall_left [N];
    int          flush_left [N];
    longint      exp_sc [N];
    longint      exp_fc [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    endtask

    // Compare all instances against the model for the current cycle, then
    // advance the model to what the coming rising edge will do.
    task automatic check_all();
        bit lu, e_pc, e_ifw, e_iff, e_idf;
        int e_hs, l_cyc, f_cyc;
        lu = idex_MemRead && (idex_rd != 0) &&
             ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
        for (int i = 0; i < N; i++) begin
            l_cyc = int'(LSC_V[i*4 +: 4]);
            f_cyc = int'(FLC_V[i*4 +: 4]);
            if (!reset) begin
                stall_left[i] = 0;
                flush_left[i] = 0;
                exp_sc[i] = 0;
                exp_fc[i] = 0;
                e_hs = 0;
                {e_pc, e_ifw, e_iff, e_idf} = 4'b0011;
            end else begin
                e_hs = (flush_left[i] > 0) ? 2 : (stall_left[i] > 0) ? 1 : 0;
                if (exmem_branch_taken) begin
                    {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
                    flush_left[i] = f_cyc - 1;
                    stall_left[i] = 0;
                end else if (flush_left[i] > 0) begin
                    {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
                    flush_left[i]--;
                end else if (stall_left[i] > 0) begin
                    {e_pc, e_ifw, e_iff, e_idf} = 4'b0001;
                    stall_left[i]--;
                end else if (lu) begin
                    {e_pc, e_ifw, e_iff, e_idf} = 4'b0001;
                    stall_left[i] = l_cyc - 1;
                end else begin
                    {e_pc, e_ifw, e_iff, e_idf} = 4'b1100;
                end
            end
            chk($sformatf("PCWrite[%0d]", i),    32'(pcw[i]),  32'(e_pc));
            chk($sformatf("IFID_Write[%0d]", i), 32'(ifw[i]),  32'(e_ifw));
            chk($sformatf("IFID_Flush[%0d]", i), 32'(iffl[i]), 32'(e_iff));
            chk($sformatf("IDEX_Flush[%0d]", i), 32'(idfl[i]), 32'(e_idf));
            chk($sformatf("haz_state[%0d]", i),  32'(hs[i]),   32'(e_hs));
`ifdef HAZARD_STATS_EN
            chk($sformatf("stall_count[%0d]", i), sc[i], 32'(exp_sc[i]));
            chk($sformatf("flush_count[%0d]", i), fc[i], 32'(exp_fc[i]));
`else
            chk($sformatf("stall_count[%0d]", i), sc[i], 32'd0);
            chk($sformatf("flush_count[%0d]", i), fc[i], 32'd0);
`endif
            if (reset) begin
                if (e_idf && !e_pc) exp_sc[i]++;
                if (e_iff) exp_fc[i]++;
            end
        end
    endtask

    // Entered and left at a falling clock edge.
    task automatic cycle(input bit br, input bit mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input bit u2);
        exmem_branch_taken = br;
        idex_MemRead       = mr;
        idex_rd            = rd;
        ifid_rs1           = rs1;
        ifid_rs2           = rs2;
        ifid_uses_rs2      = u2;
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset in the middle of a cycle; checked right away.
    task automatic do_reset();
        #1 reset = 1'b0;
        #1 check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        {exmem_branch_taken, idex_MemRead, ifid_uses_rs2} = 3'b000;
        {idex_rd, ifid_rs1, ifid_rs2} = 15'd0;
        for (int i = 0; i < N; i++) begin
            stall_left[i] = 0;
            flush_left[i] = 0;
            exp_sc[i] = 0;
            exp_fc[i] = 0;
        end
        @(negedge clk);
        #1 check_all();
        @(negedge clk);
        reset = 1'b1;

        // Reset release, normal operation
        idle(2);
        // Load-use on rs1, then let every instance drain
        cycle(0, 1, 5, 5, 0, 0);
        idle(5);
        // x0 never stalls; rs2 ignored unless used; rs2 used -> stall
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 1, 7, 1, 7, 0);
        cycle(0, 1, 7, 1, 7, 1);
        idle(5);
        // Branch together with load-use: flush only
        cycle(1, 1, 5, 5, 5, 1);
        idle(6);
        // Branch during stall cycle 2 aborts the stall
        cycle(0, 1, 9, 9, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        idle(6);
        // Branch in FLUSH reloads the window
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        idle(6);
        // Reset in the middle of a long flush
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        do_reset();
        idle(3);

        // Randomised traffic with small register indices to provoke hazards
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
